pulpemu_cluster_clk_ctrl: RTL and testbench

// Upstream controller for the emulator cluster clock gate: produces pulp_cluster_clk_enable for pulpemu_clk_gating.

---
 rtl/pulpemu_clk_pkg.sv | 35 +++
 rtl/pulpemu_cluster_clk_ctrl_if.sv | 16 +
 rtl/pulpemu_sat_cnt.sv | 35 +++
 rtl/pulpemu_cluster_clk_ctrl.sv | 138 +++++++++++++
 tb/tb_pulpemu_cluster_clk_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pulpemu_clk_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pulpemu_clk_pkg
//  Brief    : Shared types and helpers for the cluster clock-enable controller
//  Revision : 1.0 - initial release
// ============================================================================
package pulpemu_clk_pkg;

    localparam int c_STATE_W = 3;

    // Controller states; the encoding is exported on state_o for status reads.
    typedef enum logic [c_STATE_W-1:0] {
        ST_OFF   = 3'd0,
        ST_WAKE  = 3'd1,
        ST_ON    = 3'd2,
        ST_DRAIN = 3'd3,
        ST_GATE  = 3'd4
    } clk_state_e;

    // Timer must hold the largest window value; never narrower than one bit.
    function automatic int timer_width(input int wake, input int idle, input int gate);
        int m;
        m = wake;
        if (idle > m) m = idle;
        if (gate > m) m = gate;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

    // Timer value on the last cycle of a window; a zero window still lasts one cycle.
    function automatic int last_index(input int cycles);
        return (cycles > 1) ? (cycles - 1) : 0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pulpemu_cluster_clk_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : pulpemu_cluster_clk_ctrl_if
//  Brief    : 4-phase level req/ack clock request between SoC and cluster
//  Revision : 1.0 - initial release
// ============================================================================
interface pulpemu_cluster_clk_ctrl_if;

    logic clk_en_req;   // 1 = cluster clock wanted on
    logic clk_en_ack;   // follows req once the request is fully honoured

    modport master (output clk_en_req, input  clk_en_ack);
    modport slave  (input  clk_en_req, output clk_en_ack);

endinterface
`default_nettype wire

// File: rtl/pulpemu_sat_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : pulpemu_sat_cnt
//  Brief    : Saturating up-counter with synchronous clear
//  Revision : 1.0 - initial release
// ============================================================================
module pulpemu_sat_cnt #(
    parameter int STAT_W = 32
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              i_clear,
    input  wire logic              i_inc,
    output logic [STAT_W-1:0]      o_count
);

    localparam logic [STAT_W-1:0] c_MAX = '1;

    logic [STAT_W-1:0] r_count;

    // Count up on request, stick at all-ones, clear wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc && (r_count != c_MAX)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/pulpemu_cluster_clk_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pulpemu_cluster_clk_ctrl
//  Brief    : Turns the SoC req/ack clock request into a safe, registered
//             enable for the cluster clock gate, with idle drain before
//             gating, a settle window before acking wake, and a gated-cycle
//             statistics counter.
//  Revision : 1.0 - initial release
// ============================================================================
module pulpemu_cluster_clk_ctrl
    import pulpemu_clk_pkg::*;
#(
    parameter int WAKE_CYCLES = 4,
    parameter int IDLE_CYCLES = 8,
    parameter int GATE_CYCLES = 2,
    parameter bit RESET_ON    = 1'b0,
    parameter int STAT_W      = 32
) (
    input  wire logic                  pulp_cluster_clk,
    input  wire logic                  pulp_soc_rst_n,
    pulpemu_cluster_clk_ctrl_if.slave  req_if,
    input  wire logic                  cluster_busy_i,
    input  wire logic                  dbg_force_on_i,
    output logic                       pulp_cluster_clk_enable,
    output logic [c_STATE_W-1:0]       state_o,
    output logic [STAT_W-1:0]          gated_cnt_o
);

    localparam int                 c_TMR_W     = timer_width(WAKE_CYCLES, IDLE_CYCLES, GATE_CYCLES);
    localparam logic [c_TMR_W-1:0] c_TMR_MAX   = '1;
    localparam logic [c_TMR_W-1:0] c_WAKE_LAST = c_TMR_W'(last_index(WAKE_CYCLES));
    localparam logic [c_TMR_W-1:0] c_IDLE_LAST = c_TMR_W'(last_index(IDLE_CYCLES));
    localparam logic [c_TMR_W-1:0] c_GATE_LAST = c_TMR_W'(last_index(GATE_CYCLES));
    localparam bit                 c_IDLE_ZERO = (IDLE_CYCLES == 0);
    localparam clk_state_e         c_RST_STATE = RESET_ON ? ST_ON : ST_OFF;

    clk_state_e         r_state;
    clk_state_e         w_state_nxt;
    logic [c_TMR_W-1:0] r_timer;
    logic               r_enable;
    logic               r_ack;
    logic               w_enable_nxt;
    logic               w_ack_nxt;
    logic               w_want_on;
    logic               w_wake_done;
    logic               w_idle_done;
    logic               w_gate_done;
    logic               w_timer_run;
    logic               w_gated;

    // Debug force is simply OR-ed in, so it dominates every decision req takes part in.
    assign w_want_on   = dbg_force_on_i | req_if.clk_en_req;
    assign w_wake_done = (r_timer >= c_WAKE_LAST);
    assign w_gate_done = (r_timer >= c_GATE_LAST);
    // A zero drain window gates after one DRAIN cycle regardless of activity.
    assign w_idle_done = c_IDLE_ZERO | (!cluster_busy_i && (r_timer >= c_IDLE_LAST));
    // Timer advances in the timed states; in DRAIN only across idle cycles.
    assign w_timer_run = (r_state == ST_WAKE) || (r_state == ST_GATE) ||
                         ((r_state == ST_DRAIN) && !cluster_busy_i);
    assign w_gated     = (r_state == ST_OFF);

    // State, timer and registered outputs; timer restarts on every state change.
    always_ff @(posedge pulp_cluster_clk or negedge pulp_soc_rst_n) begin
        if (!pulp_soc_rst_n) begin
            r_state  <= c_RST_STATE;
            r_timer  <= '0;
            r_enable <= RESET_ON;
            r_ack    <= RESET_ON;
        end else begin
            r_state  <= w_state_nxt;
            r_enable <= w_enable_nxt;
            r_ack    <= w_ack_nxt;
            if ((w_state_nxt != r_state) || !w_timer_run) begin
                r_timer <= '0;
            end else if (r_timer != c_TMR_MAX) begin
                r_timer <= r_timer + 1'b1;
            end
        end
    end

    // Next-state decision; WAKE and GATE always run to completion once entered.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_OFF:   if (w_want_on)   w_state_nxt = ST_WAKE;
            ST_WAKE:  if (w_wake_done) w_state_nxt = ST_ON;
            ST_ON:    if (!w_want_on)  w_state_nxt = ST_DRAIN;
            ST_DRAIN: begin
                if (w_want_on) begin
                    w_state_nxt = ST_ON;
                end else if (w_idle_done) begin
                    w_state_nxt = ST_GATE;
                end
            end
            ST_GATE:  if (w_gate_done) w_state_nxt = ST_OFF;
            default:  w_state_nxt = c_RST_STATE;
        endcase
    end

    // Output decode from the upcoming state so enable/ack leave flops directly.
    always_comb begin
        w_enable_nxt = 1'b0;
        w_ack_nxt    = 1'b0;
        case (w_state_nxt)
            ST_WAKE: begin
                w_enable_nxt = 1'b1;
            end
            ST_ON, ST_DRAIN: begin
                w_enable_nxt = 1'b1;
                w_ack_nxt    = 1'b1;
            end
            ST_GATE: begin
                w_ack_nxt    = 1'b1;
            end
            default: begin
                w_enable_nxt = 1'b0;
                w_ack_nxt    = 1'b0;
            end
        endcase
    end

    // Statistics are only ever cleared by reset.
    pulpemu_sat_cnt #(
        .STAT_W (STAT_W)
    ) u_gated_cnt (
        .clk     (pulp_cluster_clk),
        .rst_n   (pulp_soc_rst_n),
        .i_clear (1'b0),
        .i_inc   (w_gated),
        .o_count (gated_cnt_o)
    );

    assign pulp_cluster_clk_enable = r_enable;
    assign req_if.clk_en_ack       = r_ack;
    assign state_o                 = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pulpemu_cluster_clk_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pulpemu_cluster_clk_ctrl
//  Brief    : Self-checking bench: two controller instances (cold reset with
//             32-bit stats, warm reset with 4-bit stats) driven by the same
//             directed + random stimulus and compared to a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pulpemu_cluster_clk_ctrl;
    import pulpemu_clk_pkg::*;

    localparam int c_WAKE   = 4;
    localparam int c_IDLE   = 8;
    localparam int c_GATE   = 2;
    localparam int c_SW_A   = 32;
    localparam int c_SW_B   = 4;
    localparam int c_BOUND  = 60;
    localparam int c_SEL_EN = 0;
    localparam int c_SEL_AK = 1;
    localparam int c_SEL_ST = 2;

    logic              clk      = 1'b0;
    logic              rst_n    = 1'b1;
    logic              req      = 1'b0;
    logic              busy     = 1'b0;
    logic              force_on = 1'b0;
    logic              en_a;
    logic              en_b;
    logic [2:0]        state_a;
    logic [2:0]        state_b;
    logic [c_SW_A-1:0] cnt_a;
    logic [c_SW_B-1:0] cnt_b;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;
    int n, n2, lat_en, busy_pct;

    pulpemu_cluster_clk_ctrl_if if_a ();
    pulpemu_cluster_clk_ctrl_if if_b ();
    assign if_a.clk_en_req = req;
    assign if_b.clk_en_req = req;

    pulpemu_cluster_clk_ctrl #(
        .WAKE_CYCLES (c_WAKE), .IDLE_CYCLES (c_IDLE), .GATE_CYCLES (c_GATE),
        .RESET_ON (1'b0), .STAT_W (c_SW_A)
    ) u_dut_a (
        .pulp_cluster_clk        (clk),
        .pulp_soc_rst_n          (rst_n),
        .req_if                  (if_a),
        .cluster_busy_i          (busy),
        .dbg_force_on_i          (force_on),
        .pulp_cluster_clk_enable (en_a),
        .state_o                 (state_a),
        .gated_cnt_o             (cnt_a)
    );

    pulpemu_cluster_clk_ctrl #(
        .WAKE_CYCLES (c_WAKE), .IDLE_CYCLES (c_IDLE), .GATE_CYCLES (c_GATE),
        .RESET_ON (1'b1), .STAT_W (c_SW_B)
    ) u_dut_b (
        .pulp_cluster_clk        (clk),
        .pulp_soc_rst_n          (rst_n),
        .req_if                  (if_b),
        .cluster_busy_i          (busy),
        .dbg_force_on_i          (force_on),
        .pulp_cluster_clk_enable (en_b),
        .state_o                 (state_b),
        .gated_cnt_o             (cnt_b)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    // Per instance: current phase, cycles spent in it, current run of idle
    // cycles while draining, and an unbounded count of OFF cycles.
    clk_state_e m_phase [2];
    int         m_dwell [2];
    int         m_idle  [2];
    longint     m_gcnt  [2];

    function automatic int at_least_one(input int v);
        return (v < 1) ? 1 : v;
    endfunction

    function automatic void model_enter(input int k, input clk_state_e p);
        m_phase[k] = p;
        m_dwell[k] = 0;
        m_idle[k]  = 0;
    endfunction

    function automatic void model_reset();
        model_enter(0, ST_OFF);
        model_enter(1, ST_ON);
        m_gcnt[0] = 0;
        m_gcnt[1] = 0;
    endfunction

    function automatic void model_step(input int k);
        bit want_on;
        want_on = req | force_on;
        case (m_phase[k])
            ST_OFF: begin
                m_gcnt[k] += 1;
                if (want_on) model_enter(k, ST_WAKE);
            end
            ST_WAKE: begin
                m_dwell[k] += 1;
                if (m_dwell[k] >= at_least_one(c_WAKE)) model_enter(k, ST_ON);
            end
            ST_ON: if (!want_on) model_enter(k, ST_DRAIN);
            ST_DRAIN: begin
                m_idle[k] = busy ? 0 : m_idle[k] + 1;
                if (want_on) model_enter(k, ST_ON);
                else if ((c_IDLE == 0) || (m_idle[k] >= c_IDLE)) model_enter(k, ST_GATE);
            end
            ST_GATE: begin
                m_dwell[k] += 1;
                if (m_dwell[k] >= at_least_one(c_GATE)) model_enter(k, ST_OFF);
            end
            default: model_enter(k, ST_OFF);
        endcase
    endfunction

    function automatic logic exp_en(input clk_state_e p);
        return (p == ST_WAKE) || (p == ST_ON) || (p == ST_DRAIN);
    endfunction

    function automatic logic exp_ack(input clk_state_e p);
        return (p == ST_ON) || (p == ST_DRAIN) || (p == ST_GATE);
    endfunction

    function automatic logic [63:0] sat_to(input longint v, input int w);
        logic [63:0] mx;
        logic [63:0] uv;
        mx = (64'd1 << w) - 64'd1;
        uv = v;
        return (uv > mx) ? mx : uv;
    endfunction

    // Model advances on the same edge as the DUT; async reset handled by the driver.
    always @(posedge clk) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            model_step(0);
            model_step(1);
        end
    end

    // ---------------- checking ----------------
    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Full comparison of both instances every cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check_val("a_state", state_a, m_phase[0]);
            check_val("a_en",    en_a, exp_en(m_phase[0]));
            check_val("a_ack",   if_a.clk_en_ack, exp_ack(m_phase[0]));
            check_val("a_cnt",   cnt_a, sat_to(m_gcnt[0], c_SW_A));
            check_val("b_state", state_b, m_phase[1]);
            check_val("b_en",    en_b, exp_en(m_phase[1]));
            check_val("b_ack",   if_b.clk_en_ack, exp_ack(m_phase[1]));
            check_val("b_cnt",   cnt_b, sat_to(m_gcnt[1], c_SW_B));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] probe(input int sel);
        case (sel)
            c_SEL_EN: return {2'b00, en_a};
            c_SEL_AK: return {2'b00, if_a.clk_en_ack};
            default:  return state_a;
        endcase
    endfunction

    // Count edges until instance A shows the value; 0 means the bound expired.
    task automatic run_until(input int sel, input logic [2:0] val, output int edges);
        edges = 0;
        for (int i = 1; i <= c_BOUND; i++) begin
            tick();
            if (probe(sel) == val) begin
                edges = i;
                return;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        #1 rst_n = 1'b0;
        model_reset();
        #1 chk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_state_a", state_a, ST_OFF);
        check_val("rst_en_a",    en_a, 1'b0);
        check_val("rst_cnt_a",   cnt_a, 0);
        check_val("rst_state_b", state_b, ST_ON);
        check_val("rst_en_b",    en_b, 1'b1);
        check_val("rst_ack_b",   if_b.clk_en_ack, 1'b1);

        // Idle in OFF: stats count one per cycle.
        rst_n = 1'b1;
        repeat (25) tick();
        check_val("off_cnt_a", cnt_a, 25);
        check_val("off_state_a", state_a, ST_OFF);

        // Wake: enable one edge after req, ack after the settle window.
        req = 1'b1;
        lat_en = 0;
        n = 0;
        for (int i = 1; i <= c_BOUND; i++) begin
            tick();
            if (en_a && (lat_en == 0)) lat_en = i;
            if (if_a.clk_en_ack) begin
                n = i;
                break;
            end
        end
        check_val("wake_en_lat",  lat_en, 1);
        check_val("wake_ack_lat", n, 1 + c_WAKE);

        // Release with cluster idle: drain then gate.
        req  = 1'b0;
        busy = 1'b0;
        run_until(c_SEL_EN, 3'd0, n);
        check_val("drop_en_lat", n, 1 + c_IDLE);
        run_until(c_SEL_AK, 3'd0, n2);
        check_val("drop_ack_lat", n + n2, 1 + c_IDLE + c_GATE);

        // Short req pulse: wake is not aborted, then drains.
        req = 1'b1;
        tick();
        tick();
        req = 1'b0;
        run_until(c_SEL_AK, 3'd1, n);
        check_val("pulse_ack_lat", n + 2, 1 + c_WAKE);
        tick();
        check_val("pulse_drain", state_a, ST_DRAIN);
        run_until(c_SEL_ST, ST_OFF, n);

        // Busy sampled on the 7th edge after release restarts the idle run.
        req = 1'b1;
        run_until(c_SEL_AK, 3'd1, n);
        req = 1'b0;
        repeat (6) tick();
        busy = 1'b1;
        tick();
        busy = 1'b0;
        run_until(c_SEL_EN, 3'd0, n);
        check_val("busy_gate_lat", n + 7, 7 + c_IDLE);
        run_until(c_SEL_ST, ST_OFF, n);

        // Re-request during drain returns to ON with ack held.
        req = 1'b1;
        run_until(c_SEL_AK, 3'd1, n);
        req = 1'b0;
        repeat (3) tick();
        check_val("abort_in_drain", state_a, ST_DRAIN);
        req = 1'b1;
        tick();
        check_val("abort_state", state_a, ST_ON);
        check_val("abort_ack", if_a.clk_en_ack, 1'b1);
        req = 1'b0;
        run_until(c_SEL_ST, ST_OFF, n);

        // Debug force wakes without req and blocks gating; stats frozen.
        force_on = 1'b1;
        run_until(c_SEL_ST, ST_ON, n);
        check_val("force_on_lat", n, 1 + c_WAKE);
        repeat (40) tick();
        check_val("force_hold", state_a, ST_ON);
        check_val("force_cnt", cnt_a, sat_to(m_gcnt[0], c_SW_A));
        force_on = 1'b0;
        run_until(c_SEL_AK, 3'd0, n);
        check_val("force_drop_lat", n, 1 + c_IDLE + c_GATE);

        // 4-bit stats saturate at 15.
        repeat (20) tick();
        check_val("sat_b", cnt_b, 4'hF);
        check_val("nosat_a", cnt_a, sat_to(m_gcnt[0], c_SW_A));

        // Async reset in the middle of GATE.
        req = 1'b1;
        run_until(c_SEL_AK, 3'd1, n);
        req = 1'b0;
        repeat (1 + c_IDLE) tick();
        check_val("pre_rst_gate", state_a, ST_GATE);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_val("arst_state_a", state_a, ST_OFF);
        check_val("arst_ack_a",   if_a.clk_en_ack, 1'b0);
        check_val("arst_cnt_a",   cnt_a, 0);
        check_val("arst_cnt_b",   cnt_b, 0);
        check_val("arst_state_b", state_b, ST_ON);
        tick();
        tick();
        rst_n = 1'b1;

        // Random traffic against the model.
        busy_pct = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ((cyc % 250) == 0) begin
                case ($urandom_range(0, 3))
                    0:       busy_pct = 0;
                    1:       busy_pct = 5;
                    2:       busy_pct = 30;
                    default: busy_pct = 80;
                endcase
            end
            if ($urandom_range(0, 23) == 0) req = ~req;
            if (force_on) begin
                if ($urandom_range(0, 7) == 0) force_on = 1'b0;
            end else if ($urandom_range(0, 99) == 0) begin
                force_on = 1'b1;
            end
            busy = ($urandom_range(0, 99) < busy_pct);
            tick();
            if ($urandom_range(0, 999) == 0) begin
                #2 rst_n = 1'b0;
                model_reset();
                tick();
                rst_n = 1'b1;
            end
        end

        tick();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
